seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter PAT_W, default 3, pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8, match-counter width, legal range 1..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in  input  1  serial data bit.
REQ-006 in_vld  input  1  qualifies in; bit consumed only when high.
REQ-007 pattern  input  PAT_W  target sequence; MSB is the oldest bit, LSB the newest.
REQ-008 ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 clr  input  1  synchronous clear of history, fill count and match counter.
REQ-010 out  output  1  registered one-cycle match pulse.
REQ-011 match_cnt  output  CNT_W  saturating count of matches since reset or clr.

Function
REQ-012 Block SHALL keep a history shift register hist[PAT_W-1:0] and a fill counter fill (0..PAT_W).
REQ-013 On an edge with in_vld=1 and clr=0: hist <= {hist[PAT_W-2:0], in}; fill <= min(fill+1, PAT_W).
REQ-014 Match condition, evaluated before the edge: in_vld=1, clr=0, fill >= PAT_W-1, and {hist[PAT_W-2:0], in} == pattern.
REQ-015 out SHALL go to 1 on the edge that consumes the final pattern bit and return to 0 on the next edge unless a new match occurs; latency is 0 cycles after the sampling edge, with no combinational path from in to out.
REQ-016 With ovl=1, fill SHALL saturate at PAT_W after a match, so trailing bits count towards the next match (101 on stream 10101 gives 2 matches).
REQ-017 With ovl=0, fill SHALL reset to 0 on a match edge, so no bit is shared between matches (10101 gives 1 match).
REQ-018 With in_vld=0, hist, fill and match_cnt SHALL hold, and out SHALL be 0 on the next edge.
REQ-019 pattern and ovl SHALL be used live each cycle; a change takes effect on the next compare and does not clear the history.
REQ-020 clr=1 SHALL set fill=0, hist=0, out=0 and match_cnt=0 on the edge; clr has priority over a simultaneous in_vld, and that bit is discarded.
REQ-021 match_cnt SHALL increment by 1 on each match edge and saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-022 While rst_n=0: hist=0, fill=0, out=0, match_cnt=0, taking effect immediately with no clock required.
REQ-023 Reset asserted mid-sequence SHALL discard partial history; after deassertion, detection requires PAT_W fresh valid bits.
REQ-024 Reset deassertion SHALL be synchronised externally; the block takes no action on the deassertion edge beyond normal operation.

Configuration
REQ-025 Macro SEQ_DET_CNT_EN: when defined, the match counter exists as specified in REQ-021.
REQ-026 Without SEQ_DET_CNT_EN, match_cnt SHALL be a constant 0, no counter flops are inferred, and out behaviour is unchanged.

Verification (PAT_W=3, CNT_W=8, SEQ_DET_CNT_EN defined unless stated)
REQ-027 Pattern 101, ovl=1, valid stream 1,0,1,0,1 -> out pulses after the 3rd and 5th bits; match_cnt=2.
REQ-028 Same stream with ovl=0 -> out pulses after the 3rd bit only; match_cnt=1; a further 0,1 gives a pulse after the 7th bit and match_cnt=2.
REQ-029 Stream 1,0 then in_vld=0 for 4 cycles, then 1 -> hist held, out pulses once after the final 1, and out=0 during the gap.
REQ-030 rst_n pulsed low after 1,0, then 1 -> no pulse; then 0,1 -> pulse; match_cnt=1.
REQ-031 CNT_W=2, ovl=1, stream of 111111 with pattern 111 -> 4 matches, match_cnt saturates at 3; clr with in_vld=1 in the same cycle -> match_cnt=0, the bit is dropped, and fill=0.
REQ-032 Build without SEQ_DET_CNT_EN, stream 10101 with ovl=1 -> out pulses identical to REQ-027 and match_cnt stays 0 throughout.

Source files
------------

// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
//   Serial pattern detector. Valid bits are shifted into a history register.
//   A match fires when the newest PAT_W bits, including the bit currently
//   presented, equal `pattern`. `pattern` and `ovl` are read live on every
//   cycle. With ovl=1 trailing bits can start the next match; with ovl=0 each
//   match consumes all of its bits.
//
//   Optional feature macro: SEQ_DET_CNT_EN
//     defined   -> saturating match counter on match_cnt
//     undefined -> match_cnt tied to 0, no counter flops
//
// Parameters
//   PAT_W     pattern length in bits (2..16)
//   CNT_W     match counter width (1..32)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (deassertion synchronised
//                   externally)
//   in         in   serial data bit
//   in_vld     in   qualifies `in`
//   pattern    in   target sequence, MSB oldest / LSB newest
//   ovl        in   1 = overlapping, 0 = non-overlapping detection
//   clr        in   synchronous clear of history, fill and counter
//   out        out  registered one-cycle match pulse
//   match_cnt  out  saturating count of matches since reset/clr
// -----------------------------------------------------------------------------
module seq_det_param #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_vld,
  input  logic [PAT_W-1:0] pattern,
  input  logic             ovl,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // Once PAT_W-1 bits are held, the incoming bit can complete a pattern.
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  cand;
  logic              consume;
  logic              hit;

  // clr wins over a simultaneous valid bit; that bit is dropped.
  assign consume = in_vld & ~clr;
  assign cand    = {hist[PAT_W-2:0], in};
  assign hit     = consume && (fill >= FILL_ARM) && (cand == pattern);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else begin
      out <= hit;
      if (consume) begin
        hist <= cand;
        // Non-overlapping: forget the bits used by this match so none is shared.
        if (hit && !ovl)
          fill <= '0;
        else if (fill != FILL_MAX)
          fill <= fill + FILL_W'(1);
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (hit && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + CNT_W'(1);
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
module tb_seq_det_param;

  logic       clk;
  logic       rst_n;
  logic       in;
  logic       in_vld;
  logic [2:0] pattern;
  logic       ovl;
  logic       clr;
  logic       out_a;
  logic [7:0] cnt_a;
  logic       out_s;
  logic [1:0] cnt_s;

  // Main instance (CNT_W=8) and a narrow-counter instance (CNT_W=2) for
  // saturation; both see the same stimulus.
  seq_det_param #(.PAT_W(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_vld(in_vld), .pattern(pattern),
    .ovl(ovl), .clr(clr), .out(out_a), .match_cnt(cnt_a)
  );

  seq_det_param #(.PAT_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in(in), .in_vld(in_vld), .pattern(pattern),
    .ovl(ovl), .clr(clr), .out(out_s), .match_cnt(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic out;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  function automatic int cnt_full(input int c);
`ifdef SEQ_DET_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic int cnt_sat(input int c);
`ifdef SEQ_DET_CNT_EN
    return (c > 3) ? 3 : c;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle; expected response of that edge goes to the scoreboard.
  task automatic step(input logic b, input logic v, input logic c, input logic eo);
    exp_t e;
    @(negedge clk);
    in     = b;
    in_vld = v;
    clr    = c;
    if (c)       exp_cnt = 0;
    else if (eo) exp_cnt++;
    e.out = eo;
    e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every registered output update is checked against the queue.
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        bad = 1'b0;
        n_vec++;
        if (out_a !== e.out) begin
          bad = 1'b1;
          $display("FAIL vec%0d out: got %b want %b", n_vec, out_a, e.out);
        end
        if (out_s !== e.out) begin
          bad = 1'b1;
          $display("FAIL vec%0d out_sat: got %b want %b", n_vec, out_s, e.out);
        end
        if (cnt_a !== 8'(cnt_full(e.cnt))) begin
          bad = 1'b1;
          $display("FAIL vec%0d match_cnt: got %0d want %0d", n_vec, cnt_a, cnt_full(e.cnt));
        end
        if (cnt_s !== 2'(cnt_sat(e.cnt))) begin
          bad = 1'b1;
          $display("FAIL vec%0d match_cnt_sat: got %0d want %0d", n_vec, cnt_s, cnt_sat(e.cnt));
        end
        if (bad) n_bad++;
      end
    end
  end

  task automatic chk_zero(input string name);
    n_vec++;
    if (out_a !== 1'b0 || out_s !== 1'b0 || cnt_a !== 8'd0 || cnt_s !== 2'd0) begin
      n_bad++;
      $display("FAIL %s: got out=%b/%b cnt=%0d/%0d want all 0", name, out_a, out_s, cnt_a, cnt_s);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    in      = 1'b0;
    in_vld  = 1'b0;
    clr     = 1'b0;
    pattern = 3'b101;
    ovl     = 1'b1;
    #3;
    chk_zero("reset_no_clock");
    @(negedge clk);
    rst_n = 1'b1;

    // Overlapping 101 on 10101: pulses on bits 3 and 5.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 1, 0);

    // Non-overlapping: only bit 3 of 10101, then 0,1 completes bit 7.
    ovl = 1'b0;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 1, 0);

    // Gap of invalid cycles holds history; in toggles but is ignored.
    ovl = 1'b1;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 1, 0);

    // Reset mid-stream: stale hist=010 would make the next 1 match.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 1, 0, 0);
    drain();
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk_zero("reset_mid_stream");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 1, 0);

    // Pattern 111 on six 1s: 4 matches; narrow counter saturates at 3.
    pattern = 3'b111;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    // clr with a valid bit: bit dropped, fill back to 0.
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);

    // Live pattern change keeps history: hist ends 11, so 0 hits 110.
    pattern = 3'b110;
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
